// File: rtl/ins_exec_pkg.sv
// Shared execute-stage constants for the RV32I load/store units.
// Opcode, funct3, exception codes and the store FSM state type.
package ins_exec_pkg;

  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_ILLEGAL  = 2'd2;
  localparam logic [1:0] EXC_BUS_TMO  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE,
    ST_ERR
  } st_state_e;

endpackage

// File: rtl/st_lane_gen.sv
// Store lane generator: funct3 + ea[1:0] + rs2 -> byte enables, data.
// Ports: funct3_i, ea_lo_i, rs2_i in; be_o, data_o, misaligned_o, illegal_o out.
module st_lane_gen
  import ins_exec_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  ea_lo_i,
  input  logic [31:0] rs2_i,
  output logic [3:0]  be_o,
  output logic [31:0] data_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  always_comb begin
    be_o         = 4'b0000;
    data_o       = 32'h0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    unique case (1'b1)
      (funct3_i == F3_SB): begin
        be_o   = 4'b0001 << ea_lo_i;
        data_o = {4{rs2_i[7:0]}};
      end
      (funct3_i == F3_SH): begin
        be_o         = ea_lo_i[1] ? 4'b1100 : 4'b0011;
        data_o       = {2{rs2_i[15:0]}};
        misaligned_o = ea_lo_i[0];
      end
      (funct3_i == F3_SW): begin
        be_o         = 4'b1111;
        data_o       = rs2_i;
        misaligned_o = |ea_lo_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ins_exec_rv32i_s_st.sv
// RV32I store execution unit: EA/lane generation, one-outstanding write.
// Ports: op/decode/operands in; mem_w_* handshake; busy, done, exc_* out.
module ins_exec_rv32i_s_st
  import ins_exec_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op,
  input  logic [6:0]  ins_dec_op,
  input  logic [2:0]  ins_dec_funct3,
  input  logic [11:0] ins_dec_imm_s,
  input  logic [31:0] reg_rs1_val,
  input  logic [31:0] reg_rs2_val,
  output logic        busy,
  output logic        mem_w_req,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_w_data,
  output logic [3:0]  mem_w_be,
  input  logic        mem_w_ack,
  output logic        done,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_addr
);

  localparam bit TMO_EN = (ACK_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(ACK_TIMEOUT - 1);

  st_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       ea_q, ea_d;
  logic [1:0]        code_q, code_d;
  logic [31:0]       xaddr_q, xaddr_d;

  logic [31:0] ea;
  logic [3:0]  ln_be;
  logic [31:0] ln_data;
  logic        ln_mis;
  logic        ln_ill;
  logic        accept;

  assign ea = reg_rs1_val
            + {{20{ins_dec_imm_s[11]}}, ins_dec_imm_s};

  assign accept = op && (ins_dec_op == OPCODE_STORE);

  st_lane_gen u_lane (
    .funct3_i     (ins_dec_funct3),
    .ea_lo_i      (ea[1:0]),
    .rs2_i        (reg_rs2_val),
    .be_o         (ln_be),
    .data_o       (ln_data),
    .misaligned_o (ln_mis),
    .illegal_o    (ln_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      ea_q    <= '0;
      code_q  <= '0;
      xaddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      ea_q    <= ea_d;
      code_q  <= code_d;
      xaddr_q <= xaddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    ea_d    = ea_q;
    code_d  = code_q;
    xaddr_d = xaddr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ea_d = ea;
          if (ln_ill) begin
            state_d = ST_ERR;
            code_d  = EXC_ILLEGAL;
            xaddr_d = ea;
          end else if (ln_mis) begin
            state_d = ST_ERR;
            code_d  = EXC_MISALIGN;
            xaddr_d = ea;
          end else begin
            state_d = ST_REQ;
            addr_d  = {ea[31:2], 2'b00};
            data_d  = ln_data;
            be_d    = ln_be;
            cnt_d   = '0;
          end
        end
      end
      ST_REQ: begin
        // ack has priority over an expiring timeout
        if (mem_w_ack) begin
          state_d = ST_DONE;
          be_d    = 4'b0000;
        end else if (TMO_EN && cnt_q == TMO_LAST) begin
          state_d = ST_ERR;
          be_d    = 4'b0000;
          code_d  = EXC_BUS_TMO;
          xaddr_d = ea_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign mem_w_req  = (state_q == ST_REQ);
  assign done       = (state_q == ST_DONE);
  assign exc_valid  = (state_q == ST_ERR);
  assign mem_w_addr = addr_q;
  assign mem_w_data = data_q;
  assign mem_w_be   = be_q;
  assign exc_code   = code_q;
  assign exc_addr   = xaddr_q;

endmodule

// File: tb/tb_ins_exec_rv32i_s_st.sv
// Self-checking bench for the store unit: vector table, random vs
// model, and hand sequences for issue spacing, non-store and reset.
module tb_ins_exec_rv32i_s_st;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op;
  logic [6:0]  ins_dec_op;
  logic [2:0]  ins_dec_funct3;
  logic [11:0] ins_dec_imm_s;
  logic [31:0] reg_rs1_val;
  logic [31:0] reg_rs2_val;
  logic        busy;
  logic        mem_w_req;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;
  logic [3:0]  mem_w_be;
  logic        mem_w_ack;
  logic        done;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic [31:0] exc_addr;

  always #5 clk = ~clk;

  ins_exec_rv32i_s_st #(.ACK_TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op(op),
    .ins_dec_op(ins_dec_op), .ins_dec_funct3(ins_dec_funct3),
    .ins_dec_imm_s(ins_dec_imm_s),
    .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val),
    .busy(busy), .mem_w_req(mem_w_req), .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data), .mem_w_be(mem_w_be),
    .mem_w_ack(mem_w_ack), .done(done), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_addr(exc_addr)
  );

  typedef struct {
    int          req_n;
    int          busy_n;
    int          done_n;
    int          exc_n;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [1:0]  code;
    logic [31:0] xaddr;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [11:0] imm;
    logic [31:0] rs2;
    int          k;
    exp_t        e;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", nm, got, exp);
  endtask

  // Reference: byte-size arithmetic, independent of RTL structure.
  function automatic exp_t model(input logic [2:0] f3,
    input logic [31:0] rs1, input logic [11:0] imm,
    input logic [31:0] rs2, input int k);
    exp_t e;
    int s, n, lo;
    logic [31:0] ea;
    s = int'(imm);
    if (s >= 2048) s -= 4096;
    ea = rs1 + 32'(s);
    e = '{default: 0};
    if (f3 > 3'd2) begin
      e.busy_n = 1; e.exc_n = 1; e.code = 2'd2; e.xaddr = ea;
      return e;
    end
    n = 1 << f3;
    lo = int'(ea % 4);
    if ((ea % n) != 0) begin
      e.busy_n = 1; e.exc_n = 1; e.code = 2'd1; e.xaddr = ea;
      return e;
    end
    e.addr = ea - 32'(lo);
    e.be = 4'(((1 << n) - 1) << lo);
    for (int i = 0; i < 4; i++)
      e.data[8*i +: 8] = rs2[8*(i % n) +: 8];
    if (k == 0 || k > T) begin
      e.req_n = T; e.busy_n = T + 1; e.exc_n = 1;
      e.code = 2'd3; e.xaddr = ea;
    end else begin
      e.req_n = k; e.busy_n = k + 1; e.done_n = 1;
    end
    return e;
  endfunction

  // Issue one store; ack is raised so it is sampled at edge k
  // (k=0: never). Inputs are scrambled while busy.
  task automatic do_store(input string nm, input logic [2:0] f3,
    input logic [31:0] rs1, input logic [11:0] imm,
    input logic [31:0] rs2, input int k, input exp_t e);
    int req_n = 0, busy_n = 0, done_n = 0, exc_n = 0, unst = 0;
    logic [31:0] a = '0, d = '0, xa = '0;
    logic [3:0] b = '0, done_be = '0;
    logic [1:0] c = '0;
    int i;
    op = 1'b1; ins_dec_op = 7'b0100011; ins_dec_funct3 = f3;
    ins_dec_imm_s = imm; reg_rs1_val = rs1; reg_rs2_val = rs2;
    mem_w_ack = 1'b0;
    @(posedge clk); #1;
    for (i = 0; i < 64; i++) begin
      if (!busy) break;
      busy_n++;
      if (mem_w_req) begin
        req_n++;
        if (req_n == 1) begin
          a = mem_w_addr; b = mem_w_be; d = mem_w_data;
        end else if (a !== mem_w_addr || b !== mem_w_be ||
                     d !== mem_w_data) unst++;
      end
      if (done) begin done_n++; done_be = mem_w_be; end
      if (exc_valid) begin
        exc_n++; c = exc_code; xa = exc_addr;
      end
      op = 1'($urandom);
      ins_dec_op = ($urandom % 2) ? 7'b0100011 : 7'($urandom);
      ins_dec_funct3 = 3'($urandom);
      ins_dec_imm_s = 12'($urandom);
      reg_rs1_val = $urandom; reg_rs2_val = $urandom;
      mem_w_ack = mem_w_req ? (req_n == k) : 1'($urandom);
      @(posedge clk); #1;
    end
    op = 1'b0; mem_w_ack = 1'b0;
    if (i == 64) begin
      n_chk++;
      $display("FAIL %s hang: busy never dropped", nm);
    end
    chk({nm, " req_cycles"}, req_n, e.req_n);
    chk({nm, " busy_cycles"}, busy_n, e.busy_n);
    chk({nm, " done_pulses"}, done_n, e.done_n);
    chk({nm, " exc_pulses"}, exc_n, e.exc_n);
    if (e.req_n > 0) begin
      chk({nm, " addr"}, a, e.addr);
      chk({nm, " be"}, {28'h0, b}, {28'h0, e.be});
      chk({nm, " data"}, d, e.data);
      chk({nm, " unstable"}, unst, 0);
    end
    if (e.done_n > 0)
      chk({nm, " be_cleared"}, {28'h0, done_be}, 32'h0);
    if (e.exc_n > 0) begin
      chk({nm, " exc_code"}, {30'h0, c}, {30'h0, e.code});
      chk({nm, " exc_addr"}, xa, e.xaddr);
    end
  endtask

  function automatic exp_t ok(input int k, input logic [31:0] ad,
    input logic [3:0] be, input logic [31:0] dt);
    exp_t e;
    e = '{default: 0};
    e.req_n = k; e.busy_n = k + 1; e.done_n = 1;
    e.addr = ad; e.be = be; e.data = dt;
    return e;
  endfunction

  function automatic exp_t er(input int rq, input logic [1:0] cd,
    input logic [31:0] xa, input logic [31:0] ad,
    input logic [31:0] dt);
    exp_t e;
    e = '{default: 0};
    e.req_n = rq; e.busy_n = rq + 1; e.exc_n = 1;
    e.code = cd; e.xaddr = xa;
    e.addr = ad; e.be = 4'hF; e.data = dt;
    return e;
  endfunction

  vec_t vt[14];

  initial begin
    int rises[$];
    int bad;
    logic prev;

    vt[0]  = '{3'd2, 32'h1000, 12'h004, 32'hDEADBEEF, 3,
               ok(3, 32'h1004, 4'hF, 32'hDEADBEEF)};
    vt[1]  = '{3'd0, 32'h2000, 12'hFFF, 32'h000000A5, 1,
               ok(1, 32'h1FFC, 4'h8, 32'hA5A5A5A5)};
    vt[2]  = '{3'd0, 32'h2000, 12'h000, 32'h000000A5, 2,
               ok(2, 32'h2000, 4'h1, 32'hA5A5A5A5)};
    vt[3]  = '{3'd0, 32'h2000, 12'h001, 32'h000000A5, 1,
               ok(1, 32'h2000, 4'h2, 32'hA5A5A5A5)};
    vt[4]  = '{3'd0, 32'h2000, 12'h002, 32'h000000A5, 1,
               ok(1, 32'h2000, 4'h4, 32'hA5A5A5A5)};
    vt[5]  = '{3'd1, 32'h3000, 12'h002, 32'h1234CAFE, 1,
               ok(1, 32'h3000, 4'hC, 32'hCAFECAFE)};
    vt[6]  = '{3'd1, 32'h3000, 12'h003, 32'h1234CAFE, 1,
               er(0, 2'd1, 32'h3003, 0, 0)};
    vt[7]  = '{3'd1, 32'h3000, 12'h000, 32'h1234CAFE, 2,
               ok(2, 32'h3000, 4'h3, 32'hCAFECAFE)};
    vt[8]  = '{3'd3, 32'h4000, 12'h000, 32'h11111111, 1,
               er(0, 2'd2, 32'h4000, 0, 0)};
    vt[9]  = '{3'd2, 32'h5000, 12'h002, 32'h11111111, 1,
               er(0, 2'd1, 32'h5002, 0, 0)};
    vt[10] = '{3'd2, 32'h6000, 12'h000, 32'h01020304, 0,
               er(4, 2'd3, 32'h6000, 32'h6000, 32'h01020304)};
    vt[11] = '{3'd2, 32'h6000, 12'h004, 32'h55AA55AA, 4,
               ok(4, 32'h6004, 4'hF, 32'h55AA55AA)};
    vt[12] = '{3'd2, 32'hFFFFFFFC, 12'h004, 32'h87654321, 1,
               ok(1, 32'h0, 4'hF, 32'h87654321)};
    vt[13] = '{3'd0, 32'h0, 12'h800, 32'h0000003C, 1,
               ok(1, 32'hFFFFF800, 4'h1, 32'h3C3C3C3C)};

    rst_n = 1'b0; op = 1'b0; ins_dec_op = '0; ins_dec_funct3 = '0;
    ins_dec_imm_s = '0; reg_rs1_val = '0; reg_rs2_val = '0;
    mem_w_ack = 1'b0;
    #1;
    chk("rst busy", {31'h0, busy}, 0);
    chk("rst req", {31'h0, mem_w_req}, 0);
    chk("rst addr", mem_w_addr, 0);
    chk("rst data", mem_w_data, 0);
    chk("rst be", {28'h0, mem_w_be}, 0);
    chk("rst done", {31'h0, done}, 0);
    chk("rst exc", {31'h0, exc_valid}, 0);
    chk("rst code", {30'h0, exc_code}, 0);
    chk("rst xaddr", exc_addr, 0);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      do_store($sformatf("vec%0d", i), vt[i].f3, vt[i].rs1,
               vt[i].imm, vt[i].rs2, vt[i].k, vt[i].e);
      // model must agree with the hand-written table
      chk($sformatf("model%0d busy", i),
          model(vt[i].f3, vt[i].rs1, vt[i].imm, vt[i].rs2,
                vt[i].k).busy_n, vt[i].e.busy_n);
    end

    for (int r = 0; r < 40; r++) begin
      logic [2:0] f3; logic [31:0] rs1, rs2; logic [11:0] im;
      int k;
      f3 = ($urandom % 8 == 0) ? 3'($urandom_range(3, 7))
                               : 3'($urandom_range(0, 2));
      rs1 = $urandom; rs2 = $urandom; im = 12'($urandom);
      if ($urandom % 2) rs1[1:0] = 2'b00;
      if ($urandom % 2) im[1:0] = 2'b00;
      k = $urandom_range(0, 5);
      do_store($sformatf("rnd%0d", r), f3, rs1, im, rs2, k,
               model(f3, rs1, im, rs2, k));
    end

    // op held high: minimum issue interval is 3 cycles
    op = 1'b1; ins_dec_op = 7'b0100011; ins_dec_funct3 = 3'd2;
    ins_dec_imm_s = 12'h0; reg_rs1_val = 32'h8000;
    prev = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (mem_w_req && !prev) rises.push_back(c);
      mem_w_ack = mem_w_req;
      prev = mem_w_req;
    end
    op = 1'b0; mem_w_ack = 1'b0;
    chk("b2b rises", rises.size(), 4);
    if (rises.size() >= 2)
      chk("b2b interval", rises[1] - rises[0], 3);
    for (int c = 0; c < 8 && busy; c++) begin
      @(posedge clk); #1;
      mem_w_ack = mem_w_req;
    end
    mem_w_ack = 1'b0;

    // non-store opcode with op high: no response
    bad = 0;
    op = 1'b1; ins_dec_op = 7'b0000011; ins_dec_funct3 = 3'd2;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (busy || mem_w_req || done || exc_valid) bad++;
    end
    op = 1'b0;
    chk("nonstore idle", bad, 0);

    // reset while the request is outstanding
    op = 1'b1; ins_dec_op = 7'b0100011; ins_dec_funct3 = 3'd2;
    ins_dec_imm_s = 12'h0; reg_rs1_val = 32'h7000;
    @(posedge clk); #1; op = 1'b0;
    @(posedge clk); #1;
    chk("mid req up", {31'h0, mem_w_req}, 1);
    rst_n = 1'b0; #1;
    chk("mid rst req", {31'h0, mem_w_req}, 0);
    chk("mid rst be", {28'h0, mem_w_be}, 0);
    chk("mid rst busy", {31'h0, busy}, 0);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    mem_w_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      mem_w_ack = 1'b0;
      if (busy || mem_w_req || done || exc_valid) bad++;
    end
    chk("post rst quiet", bad, 0);
    do_store("after_rst", vt[0].f3, vt[0].rs1, vt[0].imm,
             vt[0].rs2, vt[0].k, vt[0].e);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
